// File: rtl/count_display_pkg.sv
// Shared types and constants for the two-digit seven-segment driver.
// Segment patterns are active-low, ordered g,f,e,d,c,b,a.
package count_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;
  localparam logic [1:0] AN_OFF  = 2'b11;

  // Double-dabble correction: nibbles >= 5 get +3 before the shift.
  function automatic logic [7:0] dd_adjust(
    input logic [7:0] b
  );
    logic [3:0] hi;
    logic [3:0] lo;
    hi = b[7:4];
    lo = b[3:0];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    return {hi, lo};
  endfunction

endpackage

// File: rtl/count_display_seg7_decode.sv
// BCD digit to active-low seven-segment pattern.
// Non-decimal nibbles blank the digit.
module seg7_decode
  import count_display_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display.sv
// Two-digit multiplexed seven-segment driver for the counter value.
// COUNT_DISPLAY_LZ_BLANK_EN blanks a leading zero in the tens slot.
module count_display
  import count_display_pkg::*;
#(
  parameter int COUNT_W     = 5,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] count,
  output logic [1:0]         an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam int RW =
    (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [COUNT_W-1:0] r_s1;
  logic [COUNT_W-1:0] r_s2;
  logic [COUNT_W-1:0] r_s3;
  logic [COUNT_W-1:0] r_last_val;
  logic [COUNT_W-1:0] r_sh;
  logic [7:0]         r_bcd;
  logic [2:0]         r_bit_cnt;
  state_t             r_state;
  logic [3:0]         r_tens;
  logic [3:0]         r_ones;
  logic [RW-1:0]      r_refresh_cnt;
  logic               r_digit_sel;
  logic [1:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp;

  logic                 w_start;
  logic [7:0]           w_adj;
  logic [7+COUNT_W:0]   w_cat;
  logic [3:0]           w_digit;
  logic [6:0]           w_seg_dec;
  logic [6:0]           w_seg_next;

  // Accept only a sample that held across two clocks.
  assign w_start = (r_state == ST_IDLE)
                && (r_s2 == r_s3)
                && (r_s2 != r_last_val);

  assign w_adj = dd_adjust(r_bcd);
  assign w_cat = {w_adj, r_sh} << 1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3       <= '0;
      r_last_val <= '0;
      r_sh       <= '0;
      r_bcd      <= '0;
      r_bit_cnt  <= '0;
      r_state    <= ST_IDLE;
      r_tens     <= '0;
      r_ones     <= '0;
    end else begin
      r_s1 <= count;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_sh       <= r_s2;
            r_bcd      <= '0;
            r_bit_cnt  <= '0;
            r_last_val <= r_s2;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd     <= w_cat[7+COUNT_W:COUNT_W];
          r_sh      <= w_cat[COUNT_W-1:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'(COUNT_W - 1))
            r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_tens  <= r_bcd[7:4];
          r_ones  <= r_bcd[3:0];
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_digit = r_digit_sel ? r_tens : r_ones;

  seg7_decode u_dec (
    .i_digit (w_digit),
    .o_seg   (w_seg_dec)
  );

`ifdef COUNT_DISPLAY_LZ_BLANK_EN
  assign w_seg_next =
    (r_digit_sel && (r_tens == 4'd0)) ? SEG_BLANK
                                      : w_seg_dec;
`else
  assign w_seg_next = w_seg_dec;
`endif

  // Anode and segments load together so no ghost cycle appears.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_refresh_cnt <= '0;
      r_digit_sel   <= 1'b0;
      r_an          <= AN_OFF;
      r_seg         <= SEG_BLANK;
      r_dp          <= 1'b1;
    end else begin
      if (r_refresh_cnt == RW'(REFRESH_DIV - 1)) begin
        r_refresh_cnt <= '0;
        r_digit_sel   <= ~r_digit_sel;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + RW'(1);
      end
      r_an  <= r_digit_sel ? AN_TENS : AN_ONES;
      r_seg <= w_seg_next;
      r_dp  <= 1'b1;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_count_display.sv
// Randomized self-checking bench for count_display.
// Reference model: displayed value kept as an integer, digits via /10 and %10.
module tb_count_display;

  localparam int W   = 5;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] count;
  logic [1:0]   an;
  logic [6:0]   seg;
  logic         dp;

  int checks   = 0;
  int failures = 0;
  int shown    = 0;

  always #5 clk = ~clk;

  count_display #(
    .COUNT_W     (W),
    .REFRESH_DIV (DIV)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] tens_pat(input int v);
`ifdef COUNT_DISPLAY_LZ_BLANK_EN
    if (v / 10 == 0) return 7'h7F;
`endif
    return pat(v / 10);
  endfunction

  function automatic int disp_val();
    return int'(dut.r_tens) * 10 + int'(dut.r_ones);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input int v, input string nm);
    int old_v;
    old_v = shown;
    count = W'(v);
    repeat (9) tick();
    checks++;
    if (disp_val() !== old_v) begin
      failures++;
      $display("FAIL %s early: digits=%0d expected %0d",
               nm, disp_val(), old_v);
    end
    tick();
    checks++;
    if (disp_val() !== v) begin
      failures++;
      $display("FAIL %s latency: digits=%0d expected %0d",
               nm, disp_val(), v);
    end
    shown = v;
  endtask

  task automatic scan(input int cycles, input string nm);
    logic [1:0] prev;
    int run;
    bit first;
    prev  = an;
    run   = 0;
    first = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      checks++;
      if (an == 2'b10) begin
        if (seg !== pat(shown % 10)) begin
          failures++;
          $display("FAIL %s ones seg=%h expected %h",
                   nm, seg, pat(shown % 10));
        end
      end else if (an == 2'b01) begin
        if (seg !== tens_pat(shown)) begin
          failures++;
          $display("FAIL %s tens seg=%h expected %h",
                   nm, seg, tens_pat(shown));
        end
      end else begin
        failures++;
        $display("FAIL %s an=%b expected 10 or 01", nm, an);
      end
      checks++;
      if (dp !== 1'b1) begin
        failures++;
        $display("FAIL %s dp=%b expected 1", nm, dp);
      end
      if (an != prev) begin
        if (!first) begin
          checks++;
          if (run != DIV) begin
            failures++;
            $display("FAIL %s an period=%0d expected %0d",
                     nm, run, DIV);
          end
        end
        first = 1'b0;
        run   = 1;
      end else begin
        run++;
      end
      prev = an;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    count = W'(9);
    repeat (3) tick();
    checks++;
    if (an !== 2'b11 || seg !== 7'h7F || dp !== 1'b1) begin
      failures++;
      $display("FAIL reset an=%b seg=%h dp=%b expected 11 7f 1",
               an, seg, dp);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (an !== 2'b10 || seg !== 7'h40) begin
      failures++;
      $display("FAIL reset_release an=%b seg=%h expected 10 40",
               an, seg);
    end
    repeat (20) tick();
    shown = 9;
    checks++;
    if (disp_val() !== 9) begin
      failures++;
      $display("FAIL reset_followup digits=%0d expected 9",
               disp_val());
    end
  endtask

  task automatic test_conversion();
    convert(17, "conv17");
    scan(16, "scan17");
  endtask

  task automatic test_max();
    convert(31, "max31");
    scan(12, "scan31");
    convert(0, "zero");
    scan(12, "scan0");
  endtask

  task automatic test_unstable();
    for (int i = 0; i < 20; i++) begin
      count = (i % 2 == 0) ? W'(6) : W'(5);
      tick();
      checks++;
      if (disp_val() !== shown) begin
        failures++;
        $display("FAIL unstable digits=%0d expected %0d",
                 disp_val(), shown);
      end
    end
    convert(6, "stable6");
    scan(12, "scan6");
  endtask

  task automatic test_mid_change();
    int seen_v[$];
    int seen_t[$];
    int cur;
    cur   = shown;
    count = W'(12);
    for (int t = 1; t <= 26; t++) begin
      tick();
      if (t == 5) count = W'(13);
      if (disp_val() != cur) begin
        cur = disp_val();
        seen_v.push_back(cur);
        seen_t.push_back(t);
      end
    end
    checks++;
    if (seen_v.size() != 2) begin
      failures++;
      $display("FAIL mid_change updates=%0d expected 2",
               seen_v.size());
    end else begin
      checks++;
      if (seen_v[0] != 12 || seen_t[0] != 10) begin
        failures++;
        $display("FAIL mid_first val=%0d@%0d expected 12@10",
                 seen_v[0], seen_t[0]);
      end
      checks++;
      if (seen_v[1] != 13 || seen_t[1] != 17) begin
        failures++;
        $display("FAIL mid_second val=%0d@%0d expected 13@17",
                 seen_v[1], seen_t[1]);
      end
    end
    shown = 13;
    scan(8, "scan13");
  endtask

  task automatic test_reset_mid();
    count = W'(45 % 32);
    repeat (5) tick();
    rst   = 1'b0;
    count = W'(0);
    tick();
    checks++;
    if (disp_val() !== 0 || an !== 2'b11 || seg !== 7'h7F) begin
      failures++;
      $display("FAIL reset_mid digits=%0d an=%b seg=%h expected 0 11 7f",
               disp_val(), an, seg);
    end
    rst   = 1'b1;
    shown = 0;
    repeat (15) tick();
    checks++;
    if (disp_val() !== 0) begin
      failures++;
      $display("FAIL reset_mid_after digits=%0d expected 0",
               disp_val());
    end
    scan(12, "scan_after_rst");
  endtask

  task automatic test_macro();
    convert(5, "five");
    scan(12, "scan5");
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 10; i++) begin
      v = int'($urandom_range(0, 31));
      convert(v, "rand");
      scan(9, "scan_rand");
    end
  endtask

  initial begin
    rst   = 1'b0;
    count = '0;
    test_reset();
    test_conversion();
    test_max();
    test_unstable();
    test_mid_change();
    test_reset_mid();
    test_macro();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
